// File: rtl/bayer_pattern_gen.sv
// bayer_pattern_gen
// Synthetic Bayer (GRBG) frame source producing a frame-valid / line-valid
// pixel stream with programmable geometry, blanking and test pattern.
//
// Ports
//   clk, reset           clock and synchronous active-high reset
//   enable               run request (sampled in IDLE and at frame end)
//   width, height        active pixels per line / lines per frame
//   h_blank              lv-low cycles between lines
//   v_front, v_back      fv-high, lv-low cycles before first / after last line
//   v_blank              fv-low cycles before each frame
//   pattern              0 flat Bayer, 1 column ramp, 2 row ramp, 3 moving ramp
//   ch0_val..ch3_val     flat-Bayer channel values
//   o_fv, o_lv, o_data   registered stream outputs (data is 0 while lv is low)
//   frame_count          completed frames
//   busy                 high whenever the generator is not idle
//
// state     | meaning
// ----------+------------------------------------------------
// S_IDLE    | stopped, waiting for enable with non-zero size
// S_VBLANK  | fv low between frames
// S_FV_PRE  | fv high, before first line
// S_LINE    | active pixels, lv high
// S_HBLANK  | lv low between lines
// S_FV_POST | fv high, after last line; frame ends on exit
module bayer_pattern_gen #(
    parameter int PIXEL_BITS = 10,
    parameter int MAX_COLS   = 1920,
    parameter int MAX_ROWS   = 1080,
    parameter int BLANK_BITS = 12,
    localparam int CW = $clog2(MAX_COLS),
    localparam int RW = $clog2(MAX_ROWS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [CW-1:0]         width,
    input  logic [RW-1:0]         height,
    input  logic [BLANK_BITS-1:0] h_blank,
    input  logic [BLANK_BITS-1:0] v_front,
    input  logic [BLANK_BITS-1:0] v_back,
    input  logic [BLANK_BITS-1:0] v_blank,
    input  logic [1:0]            pattern,
    input  logic [PIXEL_BITS-1:0] ch0_val,
    input  logic [PIXEL_BITS-1:0] ch1_val,
    input  logic [PIXEL_BITS-1:0] ch2_val,
    input  logic [PIXEL_BITS-1:0] ch3_val,
    output logic                  o_fv,
    output logic                  o_lv,
    output logic [PIXEL_BITS-1:0] o_data,
    output logic [31:0]           frame_count,
    output logic                  busy
);

    typedef enum logic [2:0] {
        S_IDLE, S_VBLANK, S_FV_PRE, S_LINE, S_HBLANK, S_FV_POST
    } state_t;

    state_t                         state_q, state_d;
    logic [BLANK_BITS-1:0]          cnt_q, cnt_d;
    logic [CW-1:0]                  col_q, col_d;
    logic [RW-1:0]                  row_q, row_d;
    logic [31:0]                    fc_q, fc_d;
    logic [CW-1:0]                  w_q, w_d;
    logic [RW-1:0]                  h_q, h_d;
    logic [BLANK_BITS-1:0]          hb_q, hb_d;
    logic [BLANK_BITS-1:0]          vbk_q, vbk_d;
    logic [1:0]                     pat_q, pat_d;
    logic [3:0][PIXEL_BITS-1:0]     ch_q, ch_d;
    logic                           fv_q, fv_d;
    logic                           lv_q, lv_d;
    logic [PIXEL_BITS-1:0]          data_q, data_d;
    logic                           busy_q, busy_d;

    // Down-counter load for an N-cycle interval; zero is stretched to one cycle.
    function automatic logic [BLANK_BITS-1:0] blen(input logic [BLANK_BITS-1:0] n);
        return (n == '0) ? '0 : n - 1'b1;
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        col_d   = col_q;
        row_d   = row_q;
        fc_d    = fc_q;
        w_d     = w_q;
        h_d     = h_q;
        hb_d    = hb_q;
        vbk_d   = vbk_q;
        pat_d   = pat_q;
        ch_d    = ch_q;

        case (state_q)
            S_IDLE: begin
                if (enable && width != '0 && height != '0) begin
                    state_d = S_VBLANK;
                    cnt_d   = blen(v_blank);
                end
            end
            S_VBLANK: begin
                if (cnt_q == '0) begin
                    state_d = S_FV_PRE;
                    cnt_d   = blen(v_front);
                    w_d     = (width > CW'(MAX_COLS)) ? CW'(MAX_COLS) : width;
                    h_d     = (height > RW'(MAX_ROWS)) ? RW'(MAX_ROWS) : height;
                    // A size zeroed during blanking still yields a 1x1 frame.
                    if (w_d == '0) w_d = CW'(1);
                    if (h_d == '0) h_d = RW'(1);
                    hb_d    = h_blank;
                    vbk_d   = v_back;
                    pat_d   = pattern;
                    ch_d    = {ch3_val, ch2_val, ch1_val, ch0_val};
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_FV_PRE: begin
                if (cnt_q == '0) begin
                    state_d = S_LINE;
                    col_d   = '0;
                    row_d   = '0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_LINE: begin
                if (col_q == w_q - 1'b1) begin
                    if (row_q == h_q - 1'b1) begin
                        state_d = S_FV_POST;
                        cnt_d   = blen(vbk_q);
                    end else begin
                        state_d = S_HBLANK;
                        cnt_d   = blen(hb_q);
                        row_d   = row_q + 1'b1;
                    end
                end else begin
                    col_d = col_q + 1'b1;
                end
            end
            S_HBLANK: begin
                if (cnt_q == '0) begin
                    state_d = S_LINE;
                    col_d   = '0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_FV_POST: begin
                if (cnt_q == '0) begin
                    fc_d = fc_q + 1'b1;
                    if (enable) begin
                        state_d = S_VBLANK;
                        cnt_d   = blen(v_blank);
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are decoded from the next state so they register together.
        fv_d   = (state_d == S_FV_PRE) || (state_d == S_LINE) ||
                 (state_d == S_HBLANK) || (state_d == S_FV_POST);
        lv_d   = (state_d == S_LINE);
        busy_d = (state_d != S_IDLE);
        data_d = '0;
        if (state_d == S_LINE) begin
            case (pat_q)
                // GRBG: {row[0], ~col[0]} enumerates ch0..ch3 in map order.
                2'd0:    data_d = ch_q[{row_d[0], ~col_d[0]}];
                2'd1:    data_d = PIXEL_BITS'(col_d);
                2'd2:    data_d = PIXEL_BITS'(row_d);
                default: data_d = PIXEL_BITS'(32'(col_d) + fc_q);
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            col_q   <= '0;
            row_q   <= '0;
            fc_q    <= '0;
            w_q     <= '0;
            h_q     <= '0;
            hb_q    <= '0;
            vbk_q   <= '0;
            pat_q   <= '0;
            ch_q    <= '0;
            fv_q    <= 1'b0;
            lv_q    <= 1'b0;
            data_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            col_q   <= col_d;
            row_q   <= row_d;
            fc_q    <= fc_d;
            w_q     <= w_d;
            h_q     <= h_d;
            hb_q    <= hb_d;
            vbk_q   <= vbk_d;
            pat_q   <= pat_d;
            ch_q    <= ch_d;
            fv_q    <= fv_d;
            lv_q    <= lv_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
        end
    end

    assign o_fv        = fv_q;
    assign o_lv        = lv_q;
    assign o_data      = data_q;
    assign frame_count = fc_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_bayer_pattern_gen.sv
`timescale 1ns/1ps
module tb_bayer_pattern_gen;

    localparam int BUD = 20000;

    logic        clk = 1'b0;
    logic        reset, enable;
    logic [10:0] width, height;
    logic [11:0] h_blank, v_front, v_back, v_blank;
    logic [1:0]  pattern;
    logic [9:0]  ch0_val, ch1_val, ch2_val, ch3_val;
    logic        o_fv, o_lv, busy;
    logic [9:0]  o_data;
    logic [31:0] frame_count;

    bayer_pattern_gen dut (
        .clk(clk), .reset(reset), .enable(enable),
        .width(width), .height(height),
        .h_blank(h_blank), .v_front(v_front), .v_back(v_back), .v_blank(v_blank),
        .pattern(pattern),
        .ch0_val(ch0_val), .ch1_val(ch1_val), .ch2_val(ch2_val), .ch3_val(ch3_val),
        .o_fv(o_fv), .o_lv(o_lv), .o_data(o_data),
        .frame_count(frame_count), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    int total = 0;
    int bad   = 0;
    int mdl_fc = 0;
    int q_data[$];
    int q_len[$];
    int q_gap[$];

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int eff(input int x);
        return (x == 0) ? 1 : x;
    endfunction

    // Reference pixel value straight from the channel map / pattern rules.
    function automatic int pix(input int r, input int c);
        case (pattern)
            2'd0: begin
                if (r % 2 == 0) return (c % 2 == 1) ? int'(ch0_val) : int'(ch1_val);
                else            return (c % 2 == 1) ? int'(ch2_val) : int'(ch3_val);
            end
            2'd1:    return c % 1024;
            2'd2:    return r % 1024;
            default: return (c + mdl_fc) % 1024;
        endcase
    endfunction

    task automatic push_frame(output int hi_exp);
        int ew, eh;
        ew = (int'(width) > 1920) ? 1920 : int'(width);
        eh = (int'(height) > 1080) ? 1080 : int'(height);
        for (int r = 0; r < eh; r++) begin
            for (int c = 0; c < ew; c++) q_data.push_back(pix(r, c));
            q_len.push_back(ew);
            if (r > 0) q_gap.push_back(eff(int'(h_blank)));
        end
        hi_exp = eff(int'(v_front)) + eh * ew + (eh - 1) * eff(int'(h_blank)) + eff(int'(v_back));
    endtask

    // Monitor: pops expectations whenever the stream shows pixels, line ends or gaps.
    initial begin
        int run, gap;
        run = 0;
        gap = -1;
        forever begin
            @(negedge clk);
            if (reset) begin
                run = 0;
                gap = -1;
            end else if (o_lv) begin
                if (run == 0 && gap >= 0) begin
                    if (q_gap.size() == 0) chk("lv_gap_unexpected", gap, -1);
                    else                   chk("lv_gap", gap, q_gap.pop_front());
                end
                gap = -1;
                if (q_data.size() == 0) chk("pixel_unexpected", o_data, -1);
                else                    chk("pixel", o_data, q_data.pop_front());
                run++;
            end else begin
                chk("data_zero_lv_low", o_data, 0);
                if (run > 0) begin
                    if (q_len.size() == 0) chk("line_unexpected", run, -1);
                    else                   chk("line_len", run, q_len.pop_front());
                    run = 0;
                    gap = 1;
                end else if (gap >= 0) begin
                    gap++;
                end
                if (!o_fv) gap = -1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input int w, input int h, input int hb, input int vf,
                           input int vbk, input int vbl, input int pat,
                           input int c0, input int c1, input int c2, input int c3);
        width = 11'(w);   height = 11'(h);
        h_blank = 12'(hb); v_front = 12'(vf); v_back = 12'(vbk); v_blank = 12'(vbl);
        pattern = 2'(pat);
        ch0_val = 10'(c0); ch1_val = 10'(c1); ch2_val = 10'(c2); ch3_val = 10'(c3);
    endtask

    task automatic start_session();
        int n;
        enable = 1'b1;
        tick();
        chk("busy_after_enable", busy, 1);
        n = 1;
        while (!o_fv && n < BUD) begin tick(); n++; end
        chk("fv_start_latency", n, 1 + eff(int'(v_blank)));
    endtask

    task automatic do_frame(input int exp_low, input bit drop_en, input int new_w);
        int n, hi, hi_exp;
        n = 0;
        while (!o_fv && n < BUD) begin tick(); n++; end
        if (exp_low >= 0) chk("fv_low_cycles", n, exp_low);
        push_frame(hi_exp);
        if (new_w >= 0) width = 11'(new_w);
        hi = 1;
        n = 0;
        while (o_fv && n < BUD) begin
            if (drop_en && o_lv) enable = 1'b0;
            tick();
            n++;
            if (o_fv) hi++;
        end
        chk("fv_high_cycles", hi, hi_exp);
        mdl_fc++;
        chk("frame_count", frame_count, mdl_fc);
    endtask

    task automatic end_session();
        int seen;
        chk("busy_after_last", busy, 0);
        chk("fv_after_last", o_fv, 0);
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (o_fv || busy) seen++;
        end
        chk("no_extra_frame", seen, 0);
    endtask

    initial begin
        int n, nf;
        reset = 1'b1;
        enable = 1'b0;
        set_cfg(4, 2, 2, 1, 1, 3, 0, 1, 2, 3, 4);
        tick(); tick(); tick();
        chk("rst_fv", o_fv, 0);
        chk("rst_lv", o_lv, 0);
        chk("rst_data", o_data, 0);
        chk("rst_frame_count", frame_count, 0);
        chk("rst_busy", busy, 0);
        reset = 1'b0;

        // width 0 never leaves idle
        set_cfg(0, 2, 1, 1, 1, 1, 0, 1, 2, 3, 4);
        enable = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        chk("w0_busy", busy, 0);
        chk("w0_fv", o_fv, 0);
        enable = 1'b0;
        tick();

        // flat Bayer, back-to-back frames, then enable drop mid-line
        set_cfg(4, 2, 2, 1, 1, 3, 0, 1, 2, 3, 4);
        start_session();
        do_frame(-1, 1'b0, -1);
        do_frame(3, 1'b1, -1);
        end_session();

        // column ramp, row ramp
        set_cfg(8, 2, 1, 1, 1, 2, 1, 0, 0, 0, 0);
        start_session();
        do_frame(-1, 1'b1, -1);
        end_session();
        set_cfg(5, 3, 2, 1, 2, 1, 2, 0, 0, 0, 0);
        start_session();
        do_frame(-1, 1'b1, -1);
        end_session();

        // zero blanking stretched to one cycle, moving ramp
        set_cfg(3, 3, 0, 0, 0, 0, 3, 0, 0, 0, 0);
        start_session();
        do_frame(-1, 1'b0, -1);
        do_frame(1, 1'b1, -1);
        end_session();

        // width clamp
        set_cfg(2047, 2, 1, 1, 1, 1, 1, 0, 0, 0, 0);
        start_session();
        do_frame(-1, 1'b1, -1);
        end_session();

        // width change mid-frame applies to the next frame only
        set_cfg(4, 2, 1, 1, 1, 2, 0, 11, 22, 33, 44);
        start_session();
        do_frame(-1, 1'b0, 6);
        do_frame(2, 1'b1, -1);
        end_session();

        // reset during an active line
        set_cfg(6, 3, 2, 2, 2, 4, 3, 0, 0, 0, 0);
        start_session();
        n = 0;
        while (!o_lv && n < BUD) begin tick(); n++; end
        chk("lv_before_reset", o_lv, 1);
        reset = 1'b1;
        q_data.delete();
        q_len.delete();
        q_gap.delete();
        tick();
        chk("rst_mid_fv", o_fv, 0);
        chk("rst_mid_lv", o_lv, 0);
        chk("rst_mid_data", o_data, 0);
        chk("rst_mid_frame_count", frame_count, 0);
        reset = 1'b0;
        mdl_fc = 0;
        start_session();
        do_frame(-1, 1'b1, -1);
        end_session();

        // randomized sessions
        for (int s = 0; s < 8; s++) begin
            set_cfg($urandom_range(12, 1), $urandom_range(4, 1), $urandom_range(3, 0),
                    $urandom_range(3, 0), $urandom_range(3, 0), $urandom_range(3, 0),
                    $urandom_range(3, 0), $urandom_range(1023, 0), $urandom_range(1023, 0),
                    $urandom_range(1023, 0), $urandom_range(1023, 0));
            nf = $urandom_range(3, 1);
            start_session();
            for (int f = 0; f < nf; f++)
                do_frame((f == 0) ? -1 : eff(int'(v_blank)), f == nf - 1, -1);
            end_session();
        end

        tick(); tick();
        chk("pixels_left", q_data.size(), 0);
        chk("lines_left", q_len.size(), 0);
        chk("gaps_left", q_gap.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bayer_pattern_gen.md
# bayer_pattern_gen

Synthetic Bayer frame source driving the frame-valid/line-valid pixel stream (`fv`, `lv`, `data`) that the statistics and capture blocks consume. Generates frames of programmable size and blanking with selectable test patterns, for bring-up without a sensor and as the stimulus source for ROI/statistics checks. Sits in place of the sensor receiver output and connects directly to any stream consumer.

## Interface
- `PIXEL_BITS`, 10: bits per pixel.
- `MAX_COLS`, 1920: largest supported line width.
- `MAX_ROWS`, 1080: largest supported frame height.
- `BLANK_BITS`, 12: width of all blanking-length inputs.

- `clk`  in  1  single clock for the whole block.
- `reset`  in  1  synchronous, active-high reset, sampled on `clk` rising edge.
- `enable`  in  1  run request; level-sensitive.
- `width`  in  $clog2(MAX_COLS)  active pixels per line.
- `height`  in  $clog2(MAX_ROWS)  active lines per frame.
- `h_blank`  in  BLANK_BITS  `lv`-low cycles between lines.
- `v_front`  in  BLANK_BITS  cycles from `fv` rise to first `lv` rise.
- `v_back`  in  BLANK_BITS  cycles from last `lv` fall to `fv` fall.
- `v_blank`  in  BLANK_BITS  `fv`-low cycles before each frame.
- `pattern`  in  2  0 flat Bayer, 1 horizontal ramp, 2 vertical ramp, 3 moving ramp.
- `ch0_val`..`ch3_val`  in  PIXEL_BITS each  flat-Bayer channel values.
- `o_fv`  out  1  frame valid.
- `o_lv`  out  1  line valid.
- `o_data`  out  PIXEL_BITS  pixel data; 0 whenever `o_lv`=0.
- `frame_count`  out  32  completed frames.
- `busy`  out  1  high in every state except IDLE.

## Operation
- States: IDLE, VBLANK, FV_PRE, LINE, HBLANK, FV_POST.
- IDLE: `fv`=`lv`=0. With `enable`=1, `width`!=0 and `height`!=0, go to VBLANK. Otherwise stay in IDLE.
- VBLANK: `fv`=0 for `v_blank` cycles, then go to FV_PRE.
- Config latch: on the VBLANK→FV_PRE transition, all config inputs (`width`, `height`, blanking, `pattern`, `chN_val`) are latched. Mid-frame changes have no effect on the current frame.
- FV_PRE: `fv`=1, `lv`=0 for `v_front` cycles, then go to LINE.
- LINE: `fv`=`lv`=1 for `width` cycles; the column counter runs 0..width-1.
  - At end of a line, if row < height-1, go to HBLANK (row+1); otherwise go to FV_POST.
- HBLANK: `lv`=0 for `h_blank` cycles, then go to LINE.
- FV_POST: `fv`=1, `lv`=0 for `v_back` cycles.
  - At exit, `frame_count` increments (wraps at 2^32-1 to 0).
  - Then go to VBLANK if `enable`=1, else IDLE.
- Zero blanking lengths are treated as 1, so every `fv`/`lv` edge is separated by at least one cycle.
- Clamping: `width` > MAX_COLS is clamped to MAX_COLS; `height` > MAX_ROWS is clamped to MAX_ROWS.
- Bayer channel map (GRBG), with r = row[0] and c = col[0]:
  - r=0, c=1 → ch0
  - r=0, c=0 → ch1
  - r=1, c=1 → ch2
  - r=1, c=0 → ch3
- Pattern values:
  - 0: `chN_val` selected by the channel map.
  - 1: col[PIXEL_BITS-1:0].
  - 2: row[PIXEL_BITS-1:0].
  - 3: (col + frame_count)[PIXEL_BITS-1:0], truncated.
- Deasserting `enable` mid-frame does not abort the frame; it completes through FV_POST, then the block returns to IDLE.
- Reset, at any time: all outputs and counters go to 0 and the state goes to IDLE on the next edge.

## Timing
- Reset values: `o_fv`=0, `o_lv`=0, `o_data`=0, `frame_count`=0, `busy`=0.
- All outputs are registered. `o_fv`, `o_lv` and `o_data` change on the same edge, so data is aligned with `lv`.
- Start-up: `enable` sampled high in IDLE at edge k gives `busy`=1 after edge k; `o_fv` rises after edge k+v_blank.
- Frame period (cycles, blanks ≥1): v_blank + v_front + height·width + (height−1)·h_blank + v_back.
- `frame_count` increments on the same edge that drops `o_fv`.
- Back-to-back frames: `o_fv` is low for exactly `v_blank` cycles between frames.
- `enable` toggled during VBLANK: ignored, and the frame starts. Only the FV_POST exit samples `enable`.

## Test plan
- Flat Bayer timing: `width`=4, `height`=2, `h_blank`=2, `v_front`=1, `v_back`=1, `v_blank`=3, `pattern`=0, ch0..3 = 1,2,3,4.
  - Frame period is 15 cycles; `fv` is high for 12 cycles.
  - Line 0 data: 2,1,2,1. Line 1 data: 4,3,4,3.
  - `frame_count` is 1 after the first `fv` fall.
- Ramp: `width`=8, `pattern`=1 → each line reads 0..7. With `pattern`=2 and `height`=3, lines read 0, 1, 2 respectively.
- Enable drop mid-LINE → frame finishes with full line count and `v_back`; then `busy`=0, `fv`=0, and no further frames.
- Zero and clamp limits:
  - `width`=0 → stays in IDLE, `busy`=0.
  - `h_blank`=0 → `lv` low exactly 1 cycle between lines.
  - `width`=2047 → 1920 pixels per line.
- Reset asserted mid-LINE → next edge: `fv`=`lv`=0, `o_data`=0, `frame_count`=0. After release with `enable`=1, the first frame starts after `v_blank` cycles.
- Config change mid-frame (`width` 4→6) → current frame keeps 4-pixel lines; the next frame has 6-pixel lines. Checked against `image_stats` `num_cols` = 4, then 6.
